// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter and serializer
// state encodings, byte width, and a small index helper.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } state_t;

  // (base + off) mod n, for base < n and off <= n; avoids a general divider.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams and the serializer-side byte stream that the
// arbiter sits between. The arbiter uses the slave view; the requesters and
// serializer environment use the master view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      ser_valid;
  logic [DATA_W-1:0]         ser_data;
  logic                      ser_last;
  logic                      ser_ready;

  modport slave (
    input  req_valid, req_data, req_last, ser_ready,
    output req_ready, ser_valid, ser_data, ser_last
  );

  modport master (
    output req_valid, req_data, req_last, ser_ready,
    input  req_ready, ser_valid, ser_data, ser_last
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first eligible index
// strictly after last_i (wrapping), with last_i itself lowest priority.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] last_i,
  output logic          any_o,
  output logic [IW-1:0] pick_o
);

  assign any_o = |elig_i;

  // Scan farthest-to-nearest so the nearest eligible index after last_i wins.
  always_comb begin : scan
    int unsigned j;
    j      = 0;
    pick_o = '0;
    for (int k = N; k >= 1; k--) begin
      j = wrap_idx(32'(last_i), k, N);
      if (elig_i[j[IW-1:0]]) pick_o = j[IW-1:0];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmit path among
// NUM_REQ packet requesters, with a mid-packet stall watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int STALL_MAX = 1024,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_arbiter_if.slave     bus,
  input  logic [NUM_REQ-1:0]   cfg_enable,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 err_abort,
  output logic [IDW-1:0]       err_id
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_XFER = XFER;

  localparam int            SW         = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

  logic [0:0]         state_q,     state_d;
  logic [IDW-1:0]     grant_q,     grant_d;
  logic [IDW-1:0]     last_q,      last_d;
  logic [SW-1:0]      stall_q,     stall_d;
  logic               err_abort_q, err_abort_d;
  logic [IDW-1:0]     err_id_q,    err_id_d;

  logic [NUM_REQ-1:0] elig;
  logic               any_elig;
  logic [IDW-1:0]     pick;

  logic               in_xfer;
  logic               g_valid;
  logic               g_last;
  logic [DATA_W-1:0]  g_data;
  logic               hs;
  logic               done;
  logic               abort;

  // Only enabled requesters that currently present a byte can win.
  assign elig = bus.req_valid & cfg_enable;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_pick (
    .elig_i (elig),
    .last_i (last_q),
    .any_o  (any_elig),
    .pick_o (pick)
  );

  assign in_xfer = (state_q == S_XFER);
  assign g_valid = bus.req_valid[grant_q];
  assign g_last  = bus.req_last[grant_q];
  assign g_data  = bus.req_data[grant_q*DATA_W +: DATA_W];

  // A handshake needs the serializer ready; backpressure alone never stalls.
  assign hs    = in_xfer & g_valid & bus.ser_ready;
  assign done  = hs & g_last;
  assign abort = in_xfer & ~g_valid & (stall_q == STALL_LAST);

  assign busy      = in_xfer;
  assign grant_id  = grant_q;
  assign err_abort = err_abort_q;
  assign err_id    = err_id_q;

  // Zero-latency pass-through of the granted stream; everything idles low otherwise.
  always_comb begin
    bus.ser_valid = 1'b0;
    bus.ser_data  = '0;
    bus.ser_last  = 1'b0;
    bus.req_ready = '0;
    if (in_xfer) begin
      bus.ser_valid          = g_valid;
      bus.ser_data           = g_data;
      bus.ser_last           = g_last;
      bus.req_ready[grant_q] = bus.ser_ready;
    end
  end

  // Grant/release decisions, stall counting and abort reporting.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    stall_d     = stall_q;
    err_abort_d = 1'b0;
    err_id_d    = err_id_q;
    case (state_q)
      S_IDLE: begin
        stall_d = '0;
        if (any_elig) begin
          grant_d = pick;
          state_d = S_XFER;
        end
      end
      default: begin
        if (g_valid) begin
          stall_d = '0;
        end else if (!abort) begin
          stall_d = stall_q + 1'b1;
        end
        if (done || abort) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end
        if (abort) begin
          err_abort_d = 1'b1;
          err_id_d    = grant_q;
          stall_d     = '0;
        end
      end
    endcase
  end

  // State registers; last grant resets to the top index so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= IDW'(NUM_REQ - 1);
      stall_q     <= '0;
      err_abort_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      stall_q     <= stall_d;
      err_abort_q <= err_abort_d;
      err_id_q    <= err_id_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single byte-wide UART transmit path among NUM_REQ requesters. Each requester presents a packet as a valid/ready byte stream terminated by a last flag. The arbiter grants one requester at a time in round-robin order, holds the grant for the whole packet, and forwards bytes to the serializer. A stall watchdog releases the path if the granted requester stops supplying bytes mid-packet.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
STALL_MAX, 1024, max consecutive cycles the granted requester may hold req_valid low mid-packet before abort
IDW, $clog2(NUM_REQ), width of requester index (localparam)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*8  per-requester byte, requester i at bits [8i+7:8i]
req_last  in  NUM_REQ  per-requester last byte of packet
req_ready  out  NUM_REQ  per-requester byte accepted
cfg_enable  in  NUM_REQ  requester i may win arbitration when 1
ser_valid  out  1  byte valid to serializer
ser_data  out  8  byte to serializer
ser_last  out  1  last byte of packet
ser_ready  in  1  serializer accepts byte
busy  out  1  high while a grant is held
grant_id  out  IDW  index of current/last granted requester
err_abort  out  1  one-cycle pulse on watchdog abort
err_id  out  IDW  requester aborted, held until next abort

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, last_grant=NUM_REQ-1 so requester 0 has first priority. Stall counter=0, busy=0, grant_id=0, err_abort=0, err_id=0. All req_ready=0, ser_valid=0, ser_last=0, ser_data=0. Reset mid-packet drops the packet silently; there is no abort pulse.
- States: IDLE, XFER.
- IDLE: eligible = req_valid & cfg_enable. If eligible is nonzero, pick the first set bit searching last_grant+1, last_grant+2, ... modulo NUM_REQ. Register it into grant_id and go to XFER. Arbitration latency is 1 cycle. No bytes move in IDLE, and all req_ready are 0.
- XFER, combinational pass-through, no added latency:
  - ser_valid = req_valid[grant_id], ser_data = req_data[grant_id], ser_last = req_last[grant_id].
  - req_ready[grant_id] = ser_ready. All other req_ready are 0.
- Handshake means ser_valid & ser_ready.
  - Handshake with ser_last=1: go to IDLE, last_grant <= grant_id. The next arbitration happens in that IDLE cycle, so there is at least one idle cycle between packets.
- Stall counter:
  - Increments each XFER cycle with req_valid[grant_id]=0.
  - Clears on any cycle with req_valid[grant_id]=1.
  - ser_ready=0 (serializer backpressure) never counts as a stall.
- Abort: when the counter reaches STALL_MAX-1 and req_valid is still low:
  - Go to IDLE, last_grant <= grant_id.
  - Pulse err_abort for 1 cycle and set err_id = grant_id.
  - Clear the counter.
  - The serializer sees no ser_last for the aborted packet.
- busy = (state==XFER).
- grant_id holds its value in IDLE.
- Deasserting cfg_enable for the granted requester mid-packet does not abort; the packet completes.
- A 1-byte packet (req_last on the first byte) is legal: the grant lasts one XFER cycle if ser_ready=1.
- Requesters that deassert req_valid while ungranted are simply not considered. The arbiter does not latch requests.

Decomposition:
- Package uart_pkg: arb_state_t enum {IDLE, XFER}, DATA_W=8 constant. The uart_tx state_t is also moved here for sharing.
- Sub-module rr_pick (parameter N): combinational round-robin selector. Inputs are an eligible mask and last index. Outputs are any and the picked index. It is reusable and unit-tested separately.

Test Plan:
- Reset then single requester: req1 sends 3 bytes 0x48,0x69,0x0A with last on 0x0A, ser_ready=1.
  - Expected: grant_id=1 one cycle after req_valid; ser_data 0x48,0x69,0x0A on 3 consecutive cycles; ser_last on the 3rd; busy drops the next cycle.
- Round-robin fairness: all 4 requesters continuously valid with 1-byte packets.
  - Expected: grant order 0,1,2,3,0,1; no requester is granted twice before the others.
- Backpressure: req2 sends a 2-byte packet while ser_ready is held 0 for 50 cycles.
  - Expected: no abort; req_ready[2]=0 throughout; the bytes transfer once ser_ready=1.
- Watchdog: STALL_MAX=16; req0 sends 1 byte without last, then drops req_valid.
  - Expected: err_abort pulses exactly 16 cycles after the drop with err_id=0; the arbiter then grants pending req1.
- Masking: cfg_enable=4'b1101 with req1 and req3 valid.
  - Expected: req3 is granted and req1 is never granted. Clearing cfg_enable[3] mid-packet still completes req3's packet.
- Reset mid-packet: assert rst_n=0 during byte 2 of a 4-byte packet.
  - Expected: all outputs reach their reset values next cycle; err_abort stays 0; the next grant goes to requester 0 when it is valid.
